irq_edge_gen: RTL and testbench
===============================

Name: irq_edge_gen

Overview:
- Per-vector interrupt event generator inside the reconfigurable partition.
- Converts raw event sources into the edge-triggered req/ack protocol consumed by the static-shell IRQ shim, directly upstream of it.
- Coalesces events arriving while a request is outstanding, supports masking, and enforces a programmable minimum low time (holdoff) between successive requests so every request is a clean rising edge.

Parameters:
- IRQ_NUM, 16, number of interrupt vectors (lanes).
- HOLDOFF_W, 16, width of holdoff counter/input.

Ports:
- clk  input  1  sole clock.
- resetn  input  1  asynchronous active-low reset.
- irq_src  input  IRQ_NUM  event sources; a 0->1 transition (sampled on clk) is one event.
- irq_mask  input  IRQ_NUM  1 = lane masked: events latched, no request issued.
- irq_clear  input  IRQ_NUM  synchronous per-lane flush of latched pending event.
- holdoff  input  HOLDOFF_W  extra low cycles after each ACK; sampled at GAP entry.
- m_irq_req  output  IRQ_NUM  request to shim; held high until acked.
- m_irq_ack  input  IRQ_NUM  single-cycle ACK pulse from shim.
- irq_pending  output  IRQ_NUM  latched-but-not-yet-requested event per lane.
- irq_busy  output  IRQ_NUM  lane state != IDLE.

Behaviour:
- Lanes are fully independent; all rules below are per lane.
- Reset (async, resetn=0): state=IDLE, pend=0, prev_src=0, cnt=0. All outputs 0 immediately, without waiting for a clock edge.
  - A source already high at reset release counts as an event on the first edge.
- Event: ev = irq_src & ~prev_src. prev_src <= irq_src every cycle.
- States: IDLE, REQ, GAP, HOLD. m_irq_req = (state==REQ), registered.
- IDLE:
  - If (pend|ev) & ~mask & ~clear -> REQ, pend<=0.
  - Else pend <= (pend|ev) & ~clear.
  - Latency: src rises in cycle t (sampled at edge t+1) -> req high from cycle t+1.
- REQ:
  - ev sets pend; mask/clear changes never retract an issued request.
  - ack -> GAP.
  - ack and ev in the same cycle: go to GAP, pend<=1.
- GAP: req low for exactly this cycle.
  - If holdoff==0: (pend & ~mask) -> REQ (pend<=0), else -> IDLE.
  - Else: cnt<=holdoff-1 -> HOLD.
- HOLD:
  - cnt!=0 -> cnt<=cnt-1.
  - cnt==0 -> same decision as GAP with holdoff==0.
  - Result: req low for exactly 1+holdoff cycles between back-to-back requests.
- Any number of events between two requests coalesce into one pending request; pend is a single bit, no counting.
- clear:
  - Zeroes pend in every state.
  - In IDLE it wins over a simultaneous ev.
  - Has no effect on state.
- ack outside REQ is ignored (no state change, no error).
- holdoff changes take effect only at the next GAP entry; the counter never reloads mid-HOLD.
- Counter arithmetic is HOLDOFF_W unsigned, with no wrap: decrement only while nonzero.
- irq_pending=pend. irq_busy=(state!=IDLE). Both registered-state derived, no combinational paths from inputs to outputs.
- Decoupling handled by shim: the shim may withhold ack indefinitely; the lane stays in REQ and continues coalescing. The partition is reset after reconfiguration.

Decomposition:
- Shared package irq_pkg:
  - lane state enum (IDLE, REQ, GAP, HOLD, 2-bit encoding).
  - default IRQ_NUM and HOLDOFF_W constants, reused by the shim wrapper and testbenches.
- Sub-module irq_edge_gen_lane:
  - one vector's FSM, pend bit, prev_src and holdoff counter.
  - top instantiates IRQ_NUM copies via generate and fans out shared holdoff.

Test Plan:
- Single pulse, holdoff=0:
  - irq_src[0] high cycle 10 -> m_irq_req[0] high from cycle 11.
  - m_irq_ack[0] pulse cycle 20 -> req low cycle 21, irq_busy[0] low from cycle 22, pend=0.
- Coalescing, holdoff=0:
  - three irq_src[3] pulses during REQ (cycles 12, 14, 16), ack cycle 20 -> req low cycle 21 only, high again cycle 22, exactly one extra request; second ack -> IDLE.
- Holdoff=5:
  - pend set during REQ, ack cycle 30 -> req low cycles 31-36 (6 cycles), high again cycle 37.
  - Change holdoff to 2 during HOLD -> no effect on that gap.
- Mask/clear:
  - mask[1]=1, event cycle 5 -> no req, irq_pending[1]=1.
  - Unmask cycle 10 -> req cycle 11.
  - Repeat with irq_clear[1] cycle 8 -> irq_pending 0, no req after unmask.
- Reset mid-operation:
  - lane in REQ, resetn low asynchronously between edges -> m_irq_req, irq_pending, irq_busy 0 immediately.
  - src held high across release -> req 1 cycle after first edge.
- Corner events:
  - ack on idle lane 2 -> no change.
  - Same-cycle ack and new event on lane 4 -> GAP then REQ (holdoff=0).
  - Lanes 0 and 15 driven concurrently with differing acks -> independent timing.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: definitions shared by the interrupt edge generator, its lanes,
// the shell-side shim wrapper and testbenches.
//   lane_state_e   : per-lane FSM state, 2-bit encoding
//   IRQ_NUM_DEF    : default number of interrupt vectors
//   HOLDOFF_W_DEF  : default width of the holdoff counter/input
package irq_pkg;

  localparam int IRQ_NUM_DEF   = 16;
  localparam int HOLDOFF_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // nothing outstanding
    ST_REQ  = 2'd1,  // request driven high, waiting for ack
    ST_GAP  = 2'd2,  // mandatory single low cycle after ack
    ST_HOLD = 2'd3   // extra programmable low cycles
  } lane_state_e;

endpackage

// File: rtl/irq_edge_gen_lane.sv
// irq_edge_gen_lane: one interrupt vector. Detects rising edges on its
// source, coalesces them into a single pending bit, and drives a
// level request that stays high until acked, followed by a low time of
// 1 + holdoff cycles before the next request may rise.
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   i_src         : raw event source (rising edge = one event)
//   i_mask        : 1 = hold events as pending, issue no request
//   i_clear       : flush the pending bit
//   i_ack         : single-cycle acknowledge from the shim
//   i_holdoff     : extra low cycles, sampled on GAP entry
//   o_req         : request to shim
//   o_pending     : latched, not yet requested event
//   o_state       : current FSM state (debug / busy derivation)
module irq_edge_gen_lane
  import irq_pkg::*;
#(
  parameter int HOLDOFF_W = HOLDOFF_W_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_src,
  input  logic                 i_mask,
  input  logic                 i_clear,
  input  logic                 i_ack,
  input  logic [HOLDOFF_W-1:0] i_holdoff,
  output logic                 o_req,
  output logic                 o_pending,
  output lane_state_e          o_state
);

  lane_state_e          r_state;
  logic                 r_pend;
  logic                 r_prev_src;
  logic [HOLDOFF_W-1:0] r_cnt;

  logic w_ev;
  logic w_pend_next;
  logic w_fire;

  assign w_ev        = i_src & ~r_prev_src;
  // Pending bit if no request is issued this cycle; clear always wins.
  assign w_pend_next = (r_pend | w_ev) & ~i_clear;
  // End-of-gap decision looks only at the already latched pending bit.
  assign w_fire      = r_pend & ~i_mask;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_pend     <= 1'b0;
      r_prev_src <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_prev_src <= i_src;
      case (r_state)
        ST_IDLE: begin
          if (w_pend_next && !i_mask) begin
            r_state <= ST_REQ;
            r_pend  <= 1'b0;
          end else begin
            r_pend <= w_pend_next;
          end
        end
        ST_REQ: begin
          // The issued request is never retracted; new events coalesce.
          r_pend <= w_pend_next;
          if (i_ack) r_state <= ST_GAP;
        end
        ST_GAP: begin
          if (i_holdoff == '0) begin
            if (w_fire) begin
              r_state <= ST_REQ;
              r_pend  <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_pend  <= w_pend_next;
            end
          end else begin
            r_cnt   <= i_holdoff - HOLDOFF_W'(1);
            r_state <= ST_HOLD;
            r_pend  <= w_pend_next;
          end
        end
        ST_HOLD: begin
          if (r_cnt != '0) begin
            r_cnt  <= r_cnt - HOLDOFF_W'(1);
            r_pend <= w_pend_next;
          end else if (w_fire) begin
            r_state <= ST_REQ;
            r_pend  <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
            r_pend  <= w_pend_next;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_pend  <= 1'b0;
        end
      endcase
    end
  end

  assign o_req     = (r_state == ST_REQ);
  assign o_pending = r_pend;
  assign o_state   = r_state;

endmodule

// File: rtl/irq_edge_gen.sv
// irq_edge_gen: per-vector interrupt event generator feeding the shell
// IRQ shim. IRQ_NUM independent lanes share one holdoff setting.
// Handshake: m_irq_req[n] rises when lane n has an unmasked event and
// stays high until the shim pulses m_irq_ack[n] for one cycle; req then
// stays low for 1 + holdoff cycles so every request is a fresh rising
// edge. An ack while req is low is ignored.
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   irq_src       : event sources (0->1 sampled on clk = one event)
//   irq_mask      : 1 = latch events but issue no request
//   irq_clear     : per-lane flush of the pending bit
//   holdoff       : extra low cycles after each ack
//   m_irq_req     : request to shim
//   m_irq_ack     : ack pulse from shim
//   irq_pending   : latched-but-not-requested event per lane
//   irq_busy      : lane not idle
module irq_edge_gen
  import irq_pkg::*;
#(
  parameter int IRQ_NUM   = IRQ_NUM_DEF,
  parameter int HOLDOFF_W = HOLDOFF_W_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [IRQ_NUM-1:0]   irq_src,
  input  logic [IRQ_NUM-1:0]   irq_mask,
  input  logic [IRQ_NUM-1:0]   irq_clear,
  input  logic [HOLDOFF_W-1:0] holdoff,
  output logic [IRQ_NUM-1:0]   m_irq_req,
  input  logic [IRQ_NUM-1:0]   m_irq_ack,
  output logic [IRQ_NUM-1:0]   irq_pending,
  output logic [IRQ_NUM-1:0]   irq_busy
);

  lane_state_e w_state [IRQ_NUM];

  for (genvar g = 0; g < IRQ_NUM; g++) begin : g_lane
    irq_edge_gen_lane #(
      .HOLDOFF_W (HOLDOFF_W)
    ) u_lane (
      .clk       (clk),
      .resetn    (resetn),
      .i_src     (irq_src[g]),
      .i_mask    (irq_mask[g]),
      .i_clear   (irq_clear[g]),
      .i_ack     (m_irq_ack[g]),
      .i_holdoff (holdoff),
      .o_req     (m_irq_req[g]),
      .o_pending (irq_pending[g]),
      .o_state   (w_state[g])
    );
    assign irq_busy[g] = (w_state[g] != ST_IDLE);
  end

endmodule

// File: tb/tb_irq_edge_gen.sv
module tb_irq_edge_gen;
  import irq_pkg::*;

  localparam int N  = IRQ_NUM_DEF;
  localparam int HW = HOLDOFF_W_DEF;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          resetn;
  logic [N-1:0]  irq_src, irq_mask, irq_clear, m_irq_ack;
  logic [HW-1:0] holdoff;
  logic [N-1:0]  m_irq_req, irq_pending, irq_busy;

  always #5 clk = ~clk;

  irq_edge_gen #(.IRQ_NUM(N), .HOLDOFF_W(HW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .irq_src     (irq_src),
    .irq_mask    (irq_mask),
    .irq_clear   (irq_clear),
    .holdoff     (holdoff),
    .m_irq_req   (m_irq_req),
    .m_irq_ack   (m_irq_ack),
    .irq_pending (irq_pending),
    .irq_busy    (irq_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each lane is seen as: a request that is up or down, a pending flag,
  // and after an ack a low window (one gap cycle, then `holdoff` more
  // cycles counted down) at whose end the pending flag decides.
  bit m_req  [N];
  bit m_gap  [N];
  int m_wait [N];
  bit m_pend [N];
  bit m_prev [N];

  function automatic void model_reset();
    for (int l = 0; l < N; l++) begin
      m_req[l] = 0; m_gap[l] = 0; m_wait[l] = 0; m_pend[l] = 0; m_prev[l] = 0;
    end
  endfunction

  function automatic logic [3*N-1:0] model_out();
    logic [N-1:0] r, p, b;
    for (int l = 0; l < N; l++) begin
      r[l] = m_req[l];
      p[l] = m_pend[l];
      b[l] = m_req[l] | m_gap[l] | (m_wait[l] != 0);
    end
    return {r, p, b};
  endfunction

  function automatic logic [N-1:0] model_req_vec();
    logic [N-1:0] r;
    for (int l = 0; l < N; l++) r[l] = m_req[l];
    return r;
  endfunction

  function automatic void model_step(input logic [N-1:0] src, mask, clr, ack,
                                     input logic [HW-1:0] hold);
    for (int l = 0; l < N; l++) begin
      bit ev, np;
      ev = src[l] & ~m_prev[l];
      m_prev[l] = src[l];
      np = (m_pend[l] | ev) & ~clr[l];
      if (m_req[l]) begin
        m_pend[l] = np;
        if (ack[l]) begin
          m_req[l] = 0;
          m_gap[l] = 1;
        end
      end else if (m_gap[l] && hold != 0) begin
        m_gap[l]  = 0;
        m_wait[l] = int'(hold);
        m_pend[l] = np;
      end else if (m_wait[l] > 1) begin
        m_wait[l] = m_wait[l] - 1;
        m_pend[l] = np;
      end else if (m_gap[l] || m_wait[l] == 1) begin
        m_gap[l]  = 0;
        m_wait[l] = 0;
        if (m_pend[l] && !mask[l]) begin
          m_req[l]  = 1;
          m_pend[l] = 0;
        end else begin
          m_pend[l] = np;
        end
      end else begin
        if (np && !mask[l]) begin
          m_req[l]  = 1;
          m_pend[l] = 0;
        end else begin
          m_pend[l] = np;
        end
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  logic [3*N-1:0] exp_q[$];

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [3*N-1:0] e;
      e = exp_q.pop_front();
      check("req",  64'(m_irq_req),   64'(e[3*N-1:2*N]));
      check("pend", 64'(irq_pending), 64'(e[2*N-1:N]));
      check("busy", 64'(irq_busy),    64'(e[N-1:0]));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1: records what the DUT should show now, applies
  // the next inputs, advances the model, and returns after the edge.
  task automatic cycle(input logic [N-1:0] src, input logic [N-1:0] mask,
                       input logic [N-1:0] clr, input logic [N-1:0] ack,
                       input logic [HW-1:0] hold);
    exp_q.push_back(model_out());
    irq_src   = src;
    irq_mask  = mask;
    irq_clear = clr;
    m_irq_ack = ack;
    holdoff   = hold;
    model_step(src, mask, clr, ack, hold);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [HW-1:0] hold);
    for (int i = 0; i < n; i++) cycle('0, '0, '0, '0, hold);
  endtask

  localparam logic [N-1:0] L0  = N'(1) << 0;
  localparam logic [N-1:0] L1  = N'(1) << 1;
  localparam logic [N-1:0] L2  = N'(1) << 2;
  localparam logic [N-1:0] L3  = N'(1) << 3;
  localparam logic [N-1:0] L4  = N'(1) << 4;
  localparam logic [N-1:0] L5  = N'(1) << 5;
  localparam logic [N-1:0] L6  = N'(1) << 6;

  // ---------------- stimulus ----------------
  initial begin
    logic [HW-1:0] hold_r;
    resetn = 1'b0; irq_src = '0; irq_mask = '0; irq_clear = '0;
    m_irq_ack = '0; holdoff = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_req",  64'(m_irq_req),   64'd0);
    check("reset_pend", 64'(irq_pending), 64'd0);
    check("reset_busy", 64'(irq_busy),    64'd0);
    resetn = 1'b1;

    // Single pulse, holdoff 0
    idle(3, 0);
    cycle(L0, '0, '0, '0, 0);
    check("single_req_rise", 64'(m_irq_req[0]), 64'd1);
    idle(8, 0);
    cycle('0, '0, '0, L0, 0);
    check("single_req_low_gap", 64'(m_irq_req[0]), 64'd0);
    check("single_busy_gap",    64'(irq_busy[0]),  64'd1);
    idle(1, 0);
    check("single_busy_done", 64'(irq_busy[0]),    64'd0);
    check("single_pend_done", 64'(irq_pending[0]), 64'd0);

    // Coalescing: three events during REQ give one extra request
    cycle(L3, '0, '0, '0, 0);
    cycle('0, '0, '0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(L3, '0, '0, '0, 0);
      cycle('0, '0, '0, '0, 0);
    end
    check("coal_pend", 64'(irq_pending[3]), 64'd1);
    cycle('0, '0, '0, L3, 0);
    check("coal_gap_low", 64'(m_irq_req[3]), 64'd0);
    idle(1, 0);
    check("coal_rerequest", 64'(m_irq_req[3]), 64'd1);
    cycle('0, '0, '0, L3, 0);
    idle(1, 0);
    check("coal_idle", 64'(irq_busy[3]), 64'd0);

    // Holdoff 5, changed to 2 mid-hold
    cycle(L6, '0, '0, '0, 5);
    cycle('0, '0, '0, '0, 5);
    cycle(L6, '0, '0, '0, 5);
    cycle('0, '0, '0, L6, 5);
    check("hold_low_0", 64'(m_irq_req[6]), 64'd0);
    cycle('0, '0, '0, '0, 5);
    check("hold_low_1", 64'(m_irq_req[6]), 64'd0);
    for (int i = 2; i < 6; i++) begin
      cycle('0, '0, '0, '0, 2);
      check($sformatf("hold_low_%0d", i), 64'(m_irq_req[6]), 64'd0);
    end
    cycle('0, '0, '0, '0, 2);
    check("hold_rerequest", 64'(m_irq_req[6]), 64'd1);
    cycle('0, '0, '0, L6, 0);
    idle(2, 0);

    // Mask then unmask
    cycle(L1, L1, '0, '0, 0);
    check("mask_no_req", 64'(m_irq_req[1]),   64'd0);
    check("mask_pend",   64'(irq_pending[1]), 64'd1);
    cycle('0, L1, '0, '0, 0);
    cycle('0, '0, '0, '0, 0);
    check("unmask_req", 64'(m_irq_req[1]), 64'd1);
    cycle('0, '0, '0, L1, 0);
    idle(2, 0);
    // Mask, clear, unmask: nothing issued
    cycle(L1, L1, '0, '0, 0);
    cycle('0, L1, L1, '0, 0);
    check("clear_pend", 64'(irq_pending[1]), 64'd0);
    cycle('0, '0, '0, '0, 0);
    check("clear_no_req", 64'(m_irq_req[1]), 64'd0);

    // Ack on idle lane is ignored
    cycle('0, '0, '0, L2, 0);
    check("idle_ack_busy", 64'(irq_busy[2]), 64'd0);

    // Same-cycle ack and new event: GAP then REQ
    cycle(L4, '0, '0, '0, 0);
    cycle('0, '0, '0, '0, 0);
    cycle(L4, '0, '0, L4, 0);
    check("ackev_gap", 64'(m_irq_req[4]), 64'd0);
    cycle('0, '0, '0, '0, 0);
    check("ackev_req", 64'(m_irq_req[4]), 64'd1);
    cycle('0, '0, '0, L4, 0);
    idle(2, 0);

    // Randomized traffic on all lanes
    hold_r = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] src, mask, clr, ack;
      if ($urandom_range(0, 31) == 0) hold_r = HW'($urandom_range(0, 4));
      src  = N'($urandom);
      mask = N'($urandom & $urandom & $urandom);
      clr  = N'($urandom & $urandom & $urandom & $urandom);
      ack  = N'($urandom) & (model_req_vec() | N'($urandom & $urandom));
      cycle(src, mask, clr, ack, hold_r);
    end

    // Asynchronous reset mid-operation, source held high across release
    cycle(L5, '0, '0, '0, 0);
    check("pre_reset_req", 64'(m_irq_req[5]), 64'd1);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("async_req",  64'(m_irq_req),   64'd0);
    check("async_pend", 64'(irq_pending), 64'd0);
    check("async_busy", 64'(irq_busy),    64'd0);
    model_reset();
    irq_src = L5; irq_mask = '0; irq_clear = '0; m_irq_ack = '0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cycle(L5, '0, '0, '0, 0);
    check("release_req", 64'(m_irq_req[5]), 64'd1);
    cycle(L5, '0, '0, L5, 0);
    idle(4, 0);

    @(negedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
